// File: rtl/mux_skid_stage.sv
// N-way word selector feeding a 2-entry skid buffer with valid/ready handshake.
// Main entry drives out_data directly; the skid entry absorbs one beat while the output stalls.
module mux_skid_stage #(
    parameter int unsigned      WIDTH       = 32,
    parameter int unsigned      N_IN        = 3,
    parameter int unsigned      SEL_W       = 2,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sel_err,
    input  logic                  err_clr
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [WIDTH-1:0]  s_data, s_data_n;
    logic [WIDTH-1:0]  m_data_n;
    logic              in_ready_n;
    logic              out_valid_n;
    logic              sel_err_n;
    logic [WIDTH-1:0]  sel_word_c;
    logic              sel_bad_c;
    logic              accept_c;
    logic              pop_c;

    // Word selection; out-of-range selects fall back to DEFAULT_VAL.
    always_comb begin
        sel_word_c = DEFAULT_VAL;
        for (int unsigned k = 0; k < N_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_word_c = in_data[k*WIDTH +: WIDTH];
            end
        end
        sel_bad_c = (32'(in_sel) >= 32'(N_IN));
    end

    assign accept_c = in_valid & in_ready;
    assign pop_c    = out_valid & out_ready;

    // Next-state and datapath update; flush overrides every transition.
    always_comb begin
        state_n   = state;
        m_data_n  = out_data;
        s_data_n  = s_data;
        sel_err_n = sel_err;

        unique case (state)
            EMPTY: begin
                if (accept_c) begin
                    state_n  = ONE;
                    m_data_n = sel_word_c;
                end
            end
            ONE: begin
                if (accept_c && pop_c) begin
                    m_data_n = sel_word_c;
                end else if (accept_c) begin
                    state_n  = TWO;
                    s_data_n = sel_word_c;
                end else if (pop_c) begin
                    state_n = EMPTY;
                end
            end
            TWO: begin
                if (pop_c) begin
                    state_n  = ONE;
                    m_data_n = s_data;
                end
            end
            default: state_n = EMPTY;
        endcase

        if (flush) begin
            state_n  = EMPTY;
            m_data_n = out_data;
            s_data_n = s_data;
        end

        // Set beats clear when both happen together.
        if (accept_c && sel_bad_c && !flush) begin
            sel_err_n = 1'b1;
        end else if (err_clr) begin
            sel_err_n = 1'b0;
        end

        in_ready_n  = (state_n != TWO);
        out_valid_n = (state_n != EMPTY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_data  <= '0;
            s_data    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sel_err   <= 1'b0;
        end else begin
            state     <= state_n;
            out_data  <= m_data_n;
            s_data    <= s_data_n;
            in_ready  <= in_ready_n;
            out_valid <= out_valid_n;
            sel_err   <= sel_err_n;
        end
    end

endmodule

// File: tb/tb_mux_skid_stage.sv
// Self-checking bench for mux_skid_stage: scoreboard of expected beats plus
// a small occupancy model predicting in_ready, out_valid and sel_err.
module tb_mux_skid_stage;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned N_IN  = 3;
    localparam int unsigned SEL_W = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [N_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]      in_sel;
    logic                  in_valid;
    logic                  in_ready;
    logic                  flush;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  sel_err;
    logic                  err_clr;

    mux_skid_stage #(
        .WIDTH(WIDTH), .N_IN(N_IN), .SEL_W(SEL_W), .DEFAULT_VAL('0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .sel_err(sel_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [WIDTH-1:0] exp_q[$];
    int               m_cnt;
    logic             m_err;
    logic [WIDTH-1:0] words [N_IN];
    logic [WIDTH-1:0] last_out;

    task automatic model_reset();
        exp_q.delete();
        m_cnt    = 0;
        m_err    = 1'b0;
        last_out = '0;
    endtask

    // One clock cycle: drive inputs, check registered outputs against the model, advance.
    task automatic cycle(input logic v, input logic [SEL_W-1:0] sel,
                         input logic [WIDTH-1:0] w0, input logic [WIDTH-1:0] w1,
                         input logic [WIDTH-1:0] w2, input logic ordy,
                         input logic fl, input logic clr);
        logic             acc;
        logic             pop;
        logic             m_rdy;
        logic [WIDTH-1:0] word;
        words[0] = w0; words[1] = w1; words[2] = w2;
        in_data   = {w2, w1, w0};
        in_sel    = sel;
        in_valid  = v;
        out_ready = ordy;
        flush     = fl;
        err_clr   = clr;
        word  = (int'(sel) < int'(N_IN)) ? words[sel] : '0;
        m_rdy = (m_cnt != 2);
        acc   = v & m_rdy;
        pop   = (m_cnt != 0) & ordy;

        n_vec++;
        if (in_ready !== m_rdy) begin
            n_err++;
            $display("FAIL in_ready: got %b want %b at %0t", in_ready, m_rdy, $time);
        end
        n_vec++;
        if (out_valid !== (m_cnt != 0)) begin
            n_err++;
            $display("FAIL out_valid: got %b want %b at %0t", out_valid, (m_cnt != 0), $time);
        end
        n_vec++;
        if (sel_err !== m_err) begin
            n_err++;
            $display("FAIL sel_err: got %b want %b at %0t", sel_err, m_err, $time);
        end
        if (pop) begin
            n_vec++;
            if (out_data !== exp_q[0]) begin
                n_err++;
                $display("FAIL out_data: got %h want %h at %0t", out_data, exp_q[0], $time);
            end
        end else if (m_cnt == 0) begin
            n_vec++;
            if (out_data !== last_out) begin
                n_err++;
                $display("FAIL out_data_hold: got %h want %h at %0t", out_data, last_out, $time);
            end
        end

        if (acc && !fl && (int'(sel) >= int'(N_IN))) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
        if (fl) begin
            if (m_cnt != 0) last_out = exp_q[0];
            exp_q.delete();
            m_cnt = 0;
        end else begin
            if (pop) begin
                last_out = exp_q.pop_front();
                m_cnt--;
            end
            if (acc) begin
                exp_q.push_back(word);
                m_cnt++;
            end
            if (m_cnt != 0) last_out = exp_q[0];
        end

        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, '0, '0, '0, '0, ordy, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        cycle(1'b1, 2'd1, 32'h1, 32'hDEAD_BEEF, 32'h3, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 2'd3, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1 || sel_err !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got v=%b d=%h r=%b e=%b want v=0 d=0 r=1 e=0",
                     out_valid, out_data, in_ready, sel_err);
        end
        in_valid = 1'b0;
        model_reset();
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_streaming();
        cycle(1'b1, 2'd0, 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 2'd1, 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 2'd2, 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (out_data !== 32'hCCCC_0003 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL stream_last: got d=%h r=%b want d=cccc0003 r=1", out_data, in_ready);
        end
        idle(1'b1);
        idle(1'b1);
    endtask

    task automatic test_back_pressure();
        cycle(1'b1, 2'd0, 32'h0000_00A1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 2'd2, 32'h0, 32'h0, 32'h0000_00B2, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_full: got in_ready=%b want 0", in_ready);
        end
        // Beat offered while full must be refused.
        cycle(1'b1, 2'd1, 32'h0, 32'h0000_0BAD, 32'h0, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
    endtask

    task automatic test_bad_select();
        cycle(1'b1, 2'd3, 32'h1111, 32'h2222, 32'h3333, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (out_data !== 32'h0 || sel_err !== 1'b1) begin
            n_err++;
            $display("FAIL bad_sel: got d=%h e=%b want d=0 e=1", out_data, sel_err);
        end
        cycle(1'b1, 2'd3, 32'h1111, 32'h2222, 32'h3333, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        cycle(1'b0, 2'd0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
    endtask

    task automatic test_flush();
        cycle(1'b1, 2'd0, 32'hF000_0001, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 2'd1, 32'h0, 32'hF000_0002, 32'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 2'd3, 32'h0, 32'h0, 32'hF000_0003, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'hF000_0001) begin
            n_err++;
            $display("FAIL flush_two: got v=%b r=%b d=%h want v=0 r=1 d=f0000001",
                     out_valid, in_ready, out_data);
        end
        // Beat presented alongside flush while ready is discarded too.
        cycle(1'b1, 2'd2, 32'h0, 32'h0, 32'hF000_0004, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 10000; i++) begin
            cycle(1'($urandom_range(0, 1)), SEL_W'($urandom_range(0, 3)),
                  $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < 4; i++) idle(1'b1);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL random_drain: got %0d beats left want 0", exp_q.size());
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        err_clr   = 1'b0;
        model_reset();
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_streaming();
        test_back_pressure();
        test_bad_select();
        test_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
